// File: rtl/bin_bcd_seq.sv
// Sequential binary-to-BCD converter using shift-and-add-3, one input bit per clock.
// Accepts one word per in_valid/in_ready handshake and holds the packed BCD result until out_ready.
module bin_bcd_seq #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  busy
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WIDTH-1:0]  r_sh;
  logic [WIDTH-1:0]  w_sh_nxt;
  logic [BW-1:0]     r_acc;
  logic [BW-1:0]     w_acc_nxt;
  logic [BW-1:0]     w_adj;
  logic [BW-1:0]     w_acc_shl;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [BW-1:0]     r_res;
  logic [BW-1:0]     w_res_nxt;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_busy;

  // Add-3 correction on every accumulator nibble that is 5 or more
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
    w_acc_shl = {w_adj[BW-2:0], r_sh[WIDTH-1]};
  end

  // Next-state and working-register update
  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_res_nxt   = r_res;
    unique case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_sh_nxt    = bin;
          w_acc_nxt   = '0;
          w_cnt_nxt   = CW'(WIDTH);
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_sh_nxt  = {r_sh[WIDTH-2:0], 1'b0};
        w_acc_nxt = w_acc_shl;
        w_cnt_nxt = r_cnt - CW'(1);
        if (r_cnt == CW'(1)) begin
          w_res_nxt   = w_acc_shl;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so outputs come straight off flops
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sh        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_res       <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sh        <= w_sh_nxt;
      r_acc       <= w_acc_nxt;
      r_cnt       <= w_cnt_nxt;
      r_res       <= w_res_nxt;
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt == S_SHIFT);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign bcd       = r_res;

endmodule

// File: doc/bin_bcd_seq.md
# bin_bcd_seq

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that produces the packed BCD digits consumed by the per-digit `bcd_excess3` converters downstream. It sits directly upstream of those converters in the display/code-conversion datapath. It takes one unsigned binary word per valid/ready handshake, iterates for WIDTH cycles, and presents the decimal digits with a valid/ready output handshake.

## Interface
- WIDTH, 8: bit width of the unsigned binary input; legal range 4..16.
- DIGITS, 3: number of BCD output digits. Must satisfy 10^DIGITS > 2^WIDTH − 1; the default pair meets this.
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset; deassertion is synchronised externally.
- in_valid  input  1  `bin` holds a word to convert.
- in_ready  output  1  block can accept a word; high only in IDLE.
- bin  input  WIDTH  unsigned binary operand; sampled only on the accept edge.
- out_valid  output  1  `bcd` holds a completed result; high only in DONE.
- out_ready  input  1  downstream consumes the result.
- bcd  output  4*DIGITS  packed BCD; bits [3:0] are units, [7:4] tens, and so on. Each nibble is 0..9.
- busy  output  1  high in SHIFT.

## Operation
- Working registers:
  - `sh`: binary shift register, WIDTH bits.
  - `acc`: BCD accumulator, 4*DIGITS bits.
  - `cnt`: iteration counter, $clog2(WIDTH+1) bits.
  - `res`: output register, 4*DIGITS bits, drives `bcd`.
- IDLE:
  - Drives in_ready=1.
  - On the edge where in_valid && in_ready: sh←bin, acc←0, cnt←WIDTH, go to SHIFT.
  - in_valid low: stays in IDLE.
- SHIFT (one iteration per edge):
  - For every nibble of acc, in parallel: if nibble ≥ 5, add 3. This is a 4-bit add with no carry out; the result never exceeds 12.
  - Shift the adjusted {acc, sh} left by 1. The MSB of sh enters acc[0]. Zero fills sh[0].
  - Decrement cnt.
  - When cnt==1 at the edge: also load res←the shifted acc value, and go to DONE.
- DONE:
  - out_valid=1; res held stable.
  - On the edge where out_ready is high: go to IDLE.
  - Holds indefinitely while out_ready is low.
- No overlap: in_valid is ignored in SHIFT and DONE, and `bin` changes there have no effect.
- `res`/`bcd` change only on the SHIFT→DONE edge and on reset. They keep the last result through IDLE and the next SHIFT.
- Top-digit overflow cannot occur under the DIGITS constraint. No error flag.
- Reset (any time, including mid-SHIFT or in DONE):
  - State→IDLE; sh, acc, cnt, res→0; any in-flight conversion is discarded.
  - Output values during reset: in_ready=1, out_valid=0, busy=0, bcd=0.

## Timing
- Accept at edge k. SHIFT iterations occur at edges k+1 … k+WIDTH. out_valid is high from edge k+WIDTH (8 edges for the default).
- The output handshake at edge j returns to IDLE. The earliest next accept is edge j+1.
- Minimum period per conversion: WIDTH+2 clocks (10 for the default).
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to any output.
- busy is high for exactly WIDTH cycles per conversion.

## Test plan
- Reset values: hold rst_n=0 with random inputs -> in_ready=1, out_valid=0, busy=0, bcd=0. Release reset -> still IDLE.
- Basic conversions with out_ready=1, one at a time:
  - bin=0 -> bcd=12'h000.
  - bin=10 -> 12'h010.
  - bin=99 -> 12'h099.
  - bin=255 -> 12'h255.
  - Each case: out_valid rises exactly 8 edges after the accept edge, and busy is high for 8 cycles.
- Back-pressure: convert 8'd137 with out_ready=0 for 20 cycles -> out_valid held and bcd=12'h137 stable throughout, in_ready=0. Raise out_ready -> one-cycle handshake, IDLE on the next cycle.
- Ignored input: during SHIFT of 8'd200, pulse in_valid with bin=8'd55 -> result is 12'h200, no second result appears, and bcd keeps 12'h200 until the next conversion completes.
- Reset mid-operation: assert rst_n=0 at the 4th SHIFT cycle of 8'd250 -> bcd=0, out_valid never rises. After release, 8'd7 converts to 12'h007 with normal latency.
- Back-to-back and exhaustive: hold in_valid=1 and out_ready=1 and sweep bin over 0..255 -> every result matches the decimal reference, each nibble ≤ 9, and there is exactly one accept every 10 clocks.
